// File: rtl/bcd_entry_bin.sv
// ---------------------------------------------------------------------------
// bcd_entry_bin
// Operand-entry front end for the calculator datapath. Decimal digits arrive
// one at a time, most significant first, and are echoed as right-justified
// BCD for the display. On enter the BCD string is converted to an unsigned
// binary magnitude by a reverse double-dabble (shift right, then subtract 3
// from every BCD nibble that reads >= 8), one iteration per clock.
// The result is presented in sign-magnitude form for the ALU.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   ar           synchronous active-high reset
//   digit_valid  one-cycle strobe, digit is present
//   digit        BCD digit value (0..9 legal)
//   neg_toggle   one-cycle strobe, invert the entry sign
//   clear        one-cycle strobe, discard entry / abort conversion
//   enter        one-cycle strobe, start conversion
//   bcd_out      entered digits, right-justified
//   digit_count  digits accepted so far
//   entry_sign   current entry sign
//   busy         high while converting
//   done         one-cycle pulse when result updates
//   result       converted magnitude, held until the next done
//   result_sign  sign captured with result
//   err          sticky, a digit was rejected
// ---------------------------------------------------------------------------
module bcd_entry_bin #(
  parameter int MAX_DIGITS = 2,
  parameter int WIDTH      = 7
) (
  input  logic                    clk,
  input  logic                    ar,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    neg_toggle,
  input  logic                    clear,
  input  logic                    enter,
  output logic [4*MAX_DIGITS-1:0] bcd_out,
  output logic [1:0]              digit_count,
  output logic                    entry_sign,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic                    result_sign,
  output logic                    err
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0]       MAX_CNT   = 2'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [0:0] S_ENTRY   = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  logic [0:0]       state;
  logic [SR_W-1:0]  sr;         // {BCD nibbles, binary accumulator}
  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] iter;
  logic             sign_cap;   // sign frozen at enter
  logic             digit_ok;

  // One reverse double-dabble step: the shift moves a BCD nibble's lsb into
  // the nibble below (worth 8 instead of 10/2 = 5), so any nibble that now
  // reads >= 8 has gained 3 too many and is corrected back.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    sr_shift = sr >> 1;
    sr_next  = sr_shift;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (sr_shift[WIDTH+4*i +: 4] >= 4'd8)
        sr_next[WIDTH+4*i +: 4] = sr_shift[WIDTH+4*i +: 4] - 4'd3;
    end
  end

  assign digit_ok = (digit <= 4'd9) && (digit_count < MAX_CNT);
  assign busy     = (state == S_CONVERT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (ar) begin
      // NOTE: the conversion shift register is reset along with the outputs
      // even though it is reloaded on enter; it is small and keeps sims X-free.
      state       <= S_ENTRY;
      sr          <= '0;
      iter        <= '0;
      sign_cap    <= 1'b0;
      bcd_out     <= '0;
      digit_count <= '0;
      entry_sign  <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_sign <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == S_ENTRY) begin
        if (clear) begin
          bcd_out     <= '0;
          digit_count <= '0;
          entry_sign  <= 1'b0;
          err         <= 1'b0;
        end else if (enter) begin
          sr       <= {bcd_out, {WIDTH{1'b0}}};
          // Negative zero is presented as positive zero.
          sign_cap <= entry_sign & (bcd_out != '0);
          iter     <= '0;
          state    <= S_CONVERT;
        end else begin
          if (digit_valid) begin
            if (digit_ok) begin
              bcd_out     <= (bcd_out << 4) | BCD_W'(digit);
              digit_count <= digit_count + 2'd1;
            end else begin
              err <= 1'b1;
            end
          end
          // A sign toggle is honoured even alongside a digit strobe.
          if (neg_toggle)
            entry_sign <= ~entry_sign;
        end
      end else begin
        // Converting: only clear (abort) is honoured; other strobes are ignored.
        if (clear) begin
          bcd_out     <= '0;
          digit_count <= '0;
          entry_sign  <= 1'b0;
          err         <= 1'b0;
          state       <= S_ENTRY;
        end else begin
          sr   <= sr_next;
          iter <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            result      <= sr_next[WIDTH-1:0];
            result_sign <= sign_cap;
            done        <= 1'b1;
            bcd_out     <= '0;
            digit_count <= '0;
            entry_sign  <= 1'b0;
            err         <= 1'b0;
            state       <= S_ENTRY;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_entry_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_bin
// Self-checking bench for bcd_entry_bin. A decimal model tracks the entry;
// expected conversion results are queued at enter and popped on done.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_entry_bin;

  logic       clk = 1'b0;
  logic       ar;
  logic       digit_valid;
  logic [3:0] digit;
  logic       neg_toggle;
  logic       clear;
  logic       enter;
  logic [7:0] bcd_out;
  logic [1:0] digit_count;
  logic       entry_sign;
  logic       busy;
  logic       done;
  logic [6:0] result;
  logic       result_sign;
  logic       err;

  bcd_entry_bin #(.MAX_DIGITS(2), .WIDTH(7)) dut (
    .clk         (clk),
    .ar          (ar),
    .digit_valid (digit_valid),
    .digit       (digit),
    .neg_toggle  (neg_toggle),
    .clear       (clear),
    .enter       (enter),
    .bcd_out     (bcd_out),
    .digit_count (digit_count),
    .entry_sign  (entry_sign),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_sign (result_sign),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] mag;
    logic       sgn;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Entry model, kept in decimal terms.
  logic [7:0] m_bcd;
  int         m_val;
  int         m_cnt;
  logic       m_sign;
  logic       m_err;
  logic [6:0] m_result;
  logic       m_rsign;

  task automatic tick();
    @(negedge clk);
    digit_valid = 1'b0;
    neg_toggle  = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
    ar          = 1'b0;
  endtask

  task automatic model_clear();
    m_bcd  = '0;
    m_val  = 0;
    m_cnt  = 0;
    m_sign = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic press_digit(input logic [3:0] d, input logic with_neg);
    digit_valid = 1'b1;
    digit       = d;
    neg_toggle  = with_neg;
    if (d <= 4'd9 && m_cnt < 2) begin
      m_bcd = {m_bcd[3:0], d};
      m_val = m_val * 10 + int'(d);
      m_cnt++;
    end else begin
      m_err = 1'b1;
    end
    if (with_neg) m_sign = ~m_sign;
    tick();
    total++; if (bcd_out !== m_bcd) begin bad++; $display("FAIL digit_bcd: got %h want %h", bcd_out, m_bcd); end
    total++; if (digit_count !== 2'(m_cnt)) begin bad++; $display("FAIL digit_count: got %0d want %0d", digit_count, m_cnt); end
    total++; if (err !== m_err) begin bad++; $display("FAIL digit_err: got %b want %b", err, m_err); end
    total++; if (entry_sign !== m_sign) begin bad++; $display("FAIL digit_sign: got %b want %b", entry_sign, m_sign); end
  endtask

  task automatic press_neg();
    neg_toggle = 1'b1;
    m_sign     = ~m_sign;
    tick();
    total++; if (entry_sign !== m_sign) begin bad++; $display("FAIL neg_sign: got %b want %b", entry_sign, m_sign); end
  endtask

  // Enter, wait for done, check the popped expectation and the cleared entry.
  // poke: drive junk strobes during the first busy cycle (must be ignored).
  // extra_digit: present a digit together with enter (must be dropped).
  task automatic press_enter(input bit poke, input bit extra_digit);
    exp_t e;
    int   n;
    e.mag = 7'(m_val);
    e.sgn = m_sign && (m_val != 0);
    sb.push_back(e);
    enter = 1'b1;
    if (extra_digit) begin
      digit_valid = 1'b1;
      digit       = 4'd8;
    end
    tick();
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (poke && n == 1) begin
        digit_valid = 1'b1;
        digit       = 4'hF;
        neg_toggle  = 1'b1;
        enter       = 1'b1;
      end
      tick();
      if (poke && n == 1) begin
        total++; if (err !== 1'b0 || bcd_out !== m_bcd || entry_sign !== m_sign) begin
          bad++; $display("FAIL convert_ignore: got err=%b bcd=%h sign=%b want err=0 bcd=%h sign=%b",
                          err, bcd_out, entry_sign, m_bcd, m_sign);
        end
      end
    end
    total++; if (n != 7) begin bad++; $display("FAIL busy_cycles: got %0d want 7", n); end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL done_pulse: got %b want 1", done);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      total++; if (result !== e.mag) begin bad++; $display("FAIL result: got %0d want %0d", result, e.mag); end
      total++; if (result_sign !== e.sgn) begin bad++; $display("FAIL result_sign: got %b want %b", result_sign, e.sgn); end
      m_result = e.mag;
      m_rsign  = e.sgn;
    end
    model_clear();
    total++; if (bcd_out !== 8'h00 || digit_count !== 2'd0 || entry_sign !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL entry_cleared: got bcd=%h cnt=%0d sign=%b err=%b want all 0",
                      bcd_out, digit_count, entry_sign, err);
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single: got %b want 0", done); end
    total++; if (result !== m_result) begin bad++; $display("FAIL result_hold: got %0d want %0d", result, m_result); end
  endtask

  task automatic test_reset();
    ar = 1'b1;
    tick();
    ar = 1'b1;
    tick();
    model_clear();
    m_result = '0;
    m_rsign  = 1'b0;
    total++; if ({bcd_out, digit_count, entry_sign, busy, done, result, result_sign, err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got bcd=%h cnt=%0d sign=%b busy=%b done=%b res=%0d rs=%b err=%b want all 0",
                      bcd_out, digit_count, entry_sign, busy, done, result, result_sign, err);
    end
  endtask

  task automatic test_basic();
    press_digit(4'd4, 1'b0);
    press_digit(4'd2, 1'b0);
    total++; if (bcd_out !== 8'h42) begin bad++; $display("FAIL bcd_42: got %h want 42", bcd_out); end
    press_enter(1'b0, 1'b0);
  endtask

  task automatic test_negative();
    press_digit(4'd9, 1'b0);
    press_digit(4'd9, 1'b0);
    press_neg();
    press_enter(1'b0, 1'b0);
    press_digit(4'd5, 1'b0);
    press_enter(1'b1, 1'b0);
  endtask

  task automatic test_overflow_digit();
    press_digit(4'd1, 1'b0);
    press_digit(4'd2, 1'b0);
    press_digit(4'd3, 1'b0);
    total++; if (bcd_out !== 8'h12 || err !== 1'b1) begin
      bad++; $display("FAIL third_digit: got bcd=%h err=%b want bcd=12 err=1", bcd_out, err);
    end
    press_enter(1'b0, 1'b0);
  endtask

  task automatic test_illegal_digit();
    press_digit(4'hA, 1'b0);
    press_digit(4'd7, 1'b0);
    press_neg();
    press_neg();
    total++; if (bcd_out !== 8'h07) begin bad++; $display("FAIL bcd_07: got %h want 07", bcd_out); end
    press_enter(1'b0, 1'b0);
  endtask

  task automatic test_neg_zero();
    press_neg();
    press_enter(1'b0, 1'b0);
  endtask

  task automatic test_priority();
    // Digit plus sign toggle in one cycle applies both.
    press_digit(4'd2, 1'b1);
    press_enter(1'b0, 1'b0);
    // Enter beats a digit in the same cycle.
    press_digit(4'd3, 1'b0);
    press_enter(1'b0, 1'b1);
    // Clear beats enter in the same cycle.
    press_digit(4'd5, 1'b0);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    model_clear();
    total++; if (busy !== 1'b0 || bcd_out !== 8'h00 || digit_count !== 2'd0) begin
      bad++; $display("FAIL clear_priority: got busy=%b bcd=%h cnt=%0d want 0 00 0", busy, bcd_out, digit_count);
    end
  endtask

  task automatic test_abort(input bit use_ar);
    int seen;
    press_digit(4'd3, 1'b0);
    press_digit(4'd6, 1'b0);
    enter = 1'b1;
    tick();
    tick();
    tick();
    if (use_ar) ar = 1'b1;
    else        clear = 1'b1;
    tick();
    model_clear();
    if (use_ar) begin
      m_result = '0;
      m_rsign  = 1'b0;
    end
    total++; if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 8'h00 || digit_count !== 2'd0 ||
                 entry_sign !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL abort_state: got busy=%b done=%b bcd=%h cnt=%0d sign=%b err=%b want all 0",
                      busy, done, bcd_out, digit_count, entry_sign, err);
    end
    total++; if (result !== m_result || result_sign !== m_rsign) begin
      bad++; $display("FAIL abort_result: got %0d/%b want %0d/%b", result, result_sign, m_result, m_rsign);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
  endtask

  initial begin
    ar          = 1'b1;
    digit_valid = 1'b0;
    digit       = 4'd0;
    neg_toggle  = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
    model_clear();
    m_result = '0;
    m_rsign  = 1'b0;

    test_reset();
    test_basic();
    test_negative();
    test_overflow_digit();
    test_illegal_digit();
    test_neg_zero();
    test_priority();
    test_basic();
    test_abort(1'b0);
    test_basic();
    test_abort(1'b1);

    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
